// File: rtl/m_dm_store_buf_pkg.sv
// Shared store-type encodings, buffer entry layout and the lane/enable helpers
// used by the M-stage store buffer.
package m_dm_store_buf_pkg;

  localparam logic [1:0] TYPE_W = 2'b00;
  localparam logic [1:0] TYPE_H = 2'b01;
  localparam logic [1:0] TYPE_B = 2'b10;

  localparam int ENTRY_W = 68;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } entry_t;

  function automatic logic f_misalign(input logic [1:0] typ, input logic [1:0] a);
    logic r;
    r = 1'b1;
    case (typ)
      TYPE_W:  r = (a != 2'b00);
      TYPE_H:  r = a[0];
      TYPE_B:  r = 1'b0;
      default: r = 1'b1;
    endcase
    return r;
  endfunction

  function automatic logic [3:0] f_be(input logic [1:0] typ, input logic [1:0] a);
    logic [3:0] r;
    r = 4'b0000;
    case (typ)
      TYPE_W: r = 4'b1111;
      TYPE_H: begin
        if (a[1]) begin
          r = 4'b1100;
        end else begin
          r = 4'b0011;
        end
      end
      TYPE_B:  r = 4'b0001 << a;
      default: r = 4'b0000;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] f_wdata(input logic [1:0] typ, input logic [31:0] d);
    logic [31:0] r;
    r = 32'h0000_0000;
    case (typ)
      TYPE_W:  r = d;
      TYPE_H:  r = {2{d[15:0]}};
      TYPE_B:  r = {4{d[7:0]}};
      default: r = 32'h0000_0000;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/m_dm_store_buf_sync_fifo.sv
// Synchronous FIFO with occupancy counter; pushes when full and pops when
// empty are dropped internally so callers cannot corrupt the pointers.
module sync_fifo
  import m_dm_store_buf_pkg::*;
#(
  parameter int WIDTH = ENTRY_W,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_wdata,
  input  logic                   i_pop,
  output logic [WIDTH-1:0]       o_rdata,
  output logic                   o_empty,
  output logic                   o_full,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [PW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign o_empty = (r_count == {(PW+1){1'b0}});
  assign o_full  = (r_count == (PW+1)'(DEPTH));
  assign o_count = r_count;
  assign o_rdata = r_mem[r_rptr];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  // Entry storage carries no reset; emptiness is tracked by r_count alone.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= i_wdata;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= {PW{1'b0}};
      r_rptr  <= {PW{1'b0}};
      r_count <= {(PW+1){1'b0}};
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + PW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PW+1)'(1);
        2'b01:   r_count <= r_count - (PW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/m_dm_store_buf.sv
// M-stage store buffer: checks alignment, builds lane-replicated data and byte
// enables, and drains accepted stores to memory strictly in order.
module m_dm_store_buf
  import m_dm_store_buf_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   st_valid,
  output logic                   st_ready,
  input  logic [1:0]             st_type,
  input  logic [31:0]            st_addr,
  input  logic [31:0]            st_data,
  output logic                   st_misalign,
  output logic                   mem_req,
  input  logic                   mem_ack,
  output logic [31:0]            mem_addr,
  output logic [31:0]            mem_wdata,
  output logic [3:0]             mem_be,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  logic               w_accept;
  logic               w_bad;
  logic               w_push;
  logic               w_pop;
  logic               w_empty;
  logic               w_full;
  logic [ENTRY_W-1:0] w_head_bits;
  entry_t             w_in;
  entry_t             w_head;
  logic               r_misalign;

  assign w_accept = st_valid && st_ready;
  assign w_bad    = f_misalign(st_type, st_addr[1:0]);
  assign w_push   = w_accept && !w_bad;
  assign w_pop    = !w_empty && mem_ack;
  assign w_head   = entry_t'(w_head_bits);

  assign st_ready    = !w_full;
  assign st_misalign = r_misalign;
  assign mem_req     = !w_empty;
  assign empty       = w_empty;

  // Assemble the entry to enqueue from the incoming request.
  always_comb begin
    w_in.addr  = {st_addr[31:2], 2'b00};
    w_in.wdata = f_wdata(st_type, st_data);
    w_in.be    = f_be(st_type, st_addr[1:0]);
  end

  // The head is gated so the memory side reads all-zero whenever nothing is queued.
  always_comb begin
    if (w_empty) begin
      mem_addr  = 32'h0000_0000;
      mem_wdata = 32'h0000_0000;
      mem_be    = 4'b0000;
    end else begin
      mem_addr  = w_head.addr;
      mem_wdata = w_head.wdata;
      mem_be    = w_head.be;
    end
  end

  // One-cycle pulse for an accepted request that could not be enqueued.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_misalign <= 1'b0;
    end else begin
      r_misalign <= w_accept && w_bad;
    end
  end

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .i_push  (w_push),
    .i_wdata (w_in),
    .i_pop   (w_pop),
    .o_rdata (w_head_bits),
    .o_empty (w_empty),
    .o_full  (w_full),
    .o_count (count)
  );

endmodule

// File: tb/tb_m_dm_store_buf.sv
// Directed self-checking bench for m_dm_store_buf with hand-computed expectations.
module tb_m_dm_store_buf;
  import m_dm_store_buf_pkg::*;

  logic        clk;
  logic        reset;
  logic        st_valid;
  logic        st_ready;
  logic [1:0]  st_type;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic        st_misalign;
  logic        mem_req;
  logic        mem_ack;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        empty;
  logic [2:0]  count;

  int n_checks;
  int n_err;

  m_dm_store_buf #(.DEPTH(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .st_valid    (st_valid),
    .st_ready    (st_ready),
    .st_type     (st_type),
    .st_addr     (st_addr),
    .st_data     (st_data),
    .st_misalign (st_misalign),
    .mem_req     (mem_req),
    .mem_ack     (mem_ack),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_be      (mem_be),
    .empty       (empty),
    .count       (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] t, input logic [31:0] a, input logic [31:0] d);
    st_valid = v;
    st_type  = t;
    st_addr  = a;
    st_data  = d;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".count"},    32'(count),       32'd0);
    chk({tag, ".empty"},    32'(empty),       32'd1);
    chk({tag, ".mem_req"},  32'(mem_req),     32'd0);
    chk({tag, ".mem_addr"}, mem_addr,         32'h0);
    chk({tag, ".mem_wd"},   mem_wdata,        32'h0);
    chk({tag, ".mem_be"},   32'(mem_be),      32'h0);
    chk({tag, ".st_ready"}, 32'(st_ready),    32'd1);
    chk({tag, ".misalign"}, 32'(st_misalign), 32'd0);
  endtask

  initial begin
    n_checks = 0;
    n_err    = 0;
    reset    = 1'b0;
    mem_ack  = 1'b0;
    drive(1'b0, 2'b00, 32'h0, 32'h0);

    // Reset state, before any clock edge
    #2;
    chk_idle("rst");

    // Byte store at 0x1003, accepted on the first edge after reset release,
    // with mem_ack already high while the buffer is empty (must be ignored)
    reset   = 1'b1;
    mem_ack = 1'b1;
    drive(1'b1, TYPE_B, 32'h0000_1003, 32'h0000_00AB);
    tick();
    chk("sb.mem_req",  32'(mem_req), 32'd1);
    chk("sb.count",    32'(count),   32'd1);
    chk("sb.mem_addr", mem_addr,     32'h0000_1000);
    chk("sb.mem_be",   32'(mem_be),  32'h8);
    chk("sb.mem_wd",   mem_wdata,    32'hABAB_ABAB);
    drive(1'b0, TYPE_B, 32'h0, 32'h0);
    tick();
    chk_idle("sb_drain");

    // Halfword at 0x2002, then misaligned word at 0x2001
    mem_ack = 1'b0;
    drive(1'b1, TYPE_H, 32'h0000_2002, 32'h1234_CAFE);
    tick();
    chk("sh.count",    32'(count),  32'd1);
    chk("sh.mem_addr", mem_addr,    32'h0000_2000);
    chk("sh.mem_be",   32'(mem_be), 32'hC);
    chk("sh.mem_wd",   mem_wdata,   32'hCAFE_CAFE);
    chk("sh.misalign", 32'(st_misalign), 32'd0);
    drive(1'b1, TYPE_W, 32'h0000_2001, 32'h5555_5555);
    tick();
    chk("sw_mis.pulse", 32'(st_misalign), 32'd1);
    chk("sw_mis.count", 32'(count),       32'd1);
    drive(1'b0, TYPE_W, 32'h0, 32'h0);
    tick();
    chk("sw_mis.end",   32'(st_misalign), 32'd0);
    chk("sw_mis.count2", 32'(count),      32'd1);
    chk("sw_mis.head",  mem_wdata,        32'hCAFE_CAFE);

    // Reserved type 2'b11 and odd halfword are also rejected
    drive(1'b1, 2'b11, 32'h0000_3000, 32'h1);
    tick();
    chk("t11.pulse", 32'(st_misalign), 32'd1);
    chk("t11.count", 32'(count),       32'd1);
    drive(1'b1, TYPE_H, 32'h0000_3001, 32'h1);
    tick();
    chk("h_odd.pulse", 32'(st_misalign), 32'd1);
    chk("h_odd.count", 32'(count),       32'd1);
    drive(1'b0, TYPE_H, 32'h0, 32'h0);
    mem_ack = 1'b1;
    tick();
    chk("drain2.count", 32'(count), 32'd0);
    chk("drain2.misal", 32'(st_misalign), 32'd0);

    // Fill with mem_ack low: four word stores, fifth held
    mem_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, TYPE_W, 32'h0000_0100 + 32'(4 * i), 32'h1111_1111 * 32'(i + 1));
      tick();
    end
    chk("full.count",    32'(count),    32'd4);
    chk("full.st_ready", 32'(st_ready), 32'd0);
    chk("full.mem_addr", mem_addr,      32'h0000_0100);
    chk("full.mem_wd",   mem_wdata,     32'h1111_1111);
    drive(1'b1, TYPE_W, 32'h0000_0110, 32'h5555_5555);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("hold.count",    32'(count),    32'd4);
      chk("hold.mem_addr", mem_addr,      32'h0000_0100);
      chk("hold.mem_wd",   mem_wdata,     32'h1111_1111);
      chk("hold.mem_be",   32'(mem_be),   32'hF);
    end

    // Full, pop with st_valid still high: no push
    mem_ack = 1'b1;
    tick();
    chk("pop_full.count",    32'(count),    32'd3);
    chk("pop_full.st_ready", 32'(st_ready), 32'd1);
    chk("pop_full.mem_addr", mem_addr,      32'h0000_0104);
    chk("pop_full.mem_wd",   mem_wdata,     32'h2222_2222);

    // Asynchronous reset between edges with count=3
    drive(1'b0, TYPE_W, 32'h0, 32'h0);
    mem_ack = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    chk_idle("async_rst");
    #1;
    reset = 1'b1;
    drive(1'b1, TYPE_B, 32'h0000_4001, 32'h0000_005A);
    tick();
    chk("post_rst.count",    32'(count),   32'd1);
    chk("post_rst.mem_req",  32'(mem_req), 32'd1);
    chk("post_rst.mem_addr", mem_addr,     32'h0000_4000);
    chk("post_rst.mem_be",   32'(mem_be),  32'h2);
    chk("post_rst.mem_wd",   mem_wdata,    32'h5A5A_5A5A);
    drive(1'b0, TYPE_B, 32'h0, 32'h0);
    mem_ack = 1'b1;
    tick();
    chk("post_rst.count2", 32'(count), 32'd0);

    // Streaming: ten word stores with mem_ack high, one write per cycle
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, TYPE_W, 32'h0000_8000 + 32'(4 * k), 32'hA000_0000 + 32'(k));
      tick();
      chk("stream.count",    32'(count), 32'd1);
      chk("stream.mem_addr", mem_addr,   32'h0000_8000 + 32'(4 * k));
      chk("stream.mem_wd",   mem_wdata,  32'hA000_0000 + 32'(k));
    end
    drive(1'b0, TYPE_W, 32'h0, 32'h0);
    tick();
    chk_idle("stream_end");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
